// File: rtl/soc_router_pkg.sv
// ============================================================================
// Module      : soc_router_pkg
// Description : Shared types for the SoC address router. Contains the
//               address-map rule, the AXI4 request/response bundles, the
//               response codes, the ERR-responder state encodings and the
//               rule-match helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package soc_router_pkg;

    localparam int AXI_ID_W   = 4;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    // Wide enough for every real port plus the internal ERR port.
    localparam int PORT_IDX_W = 4;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] DECERR = 2'b11;

    typedef struct packed {
        logic [PORT_IDX_W-1:0] port_idx;
        logic [AXI_ADDR_W-1:0] base;
        logic [AXI_ADDR_W-1:0] mask;
    } rule_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]     aw_id;
        logic [AXI_ADDR_W-1:0]   aw_addr;
        logic [7:0]              aw_len;
        logic [2:0]              aw_size;
        logic [1:0]              aw_burst;
        logic                    aw_valid;
        logic [AXI_DATA_W-1:0]   w_data;
        logic [AXI_DATA_W/8-1:0] w_strb;
        logic                    w_last;
        logic                    w_valid;
        logic                    b_ready;
        logic [AXI_ID_W-1:0]     ar_id;
        logic [AXI_ADDR_W-1:0]   ar_addr;
        logic [7:0]              ar_len;
        logic [2:0]              ar_size;
        logic [1:0]              ar_burst;
        logic                    ar_valid;
        logic                    r_ready;
    } axi_req_t;

    typedef struct packed {
        logic                  aw_ready;
        logic                  w_ready;
        logic [AXI_ID_W-1:0]   b_id;
        logic [1:0]            b_resp;
        logic                  b_valid;
        logic                  ar_ready;
        logic [AXI_ID_W-1:0]   r_id;
        logic [AXI_DATA_W-1:0] r_data;
        logic [1:0]            r_resp;
        logic                  r_last;
        logic                  r_valid;
    } axi_resp_t;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_DATA = 2'd1,
        WR_RESP = 2'd2
    } err_wr_state_e;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } err_rd_state_e;

    function automatic logic rule_match(input rule_t r, input logic [AXI_ADDR_W-1:0] addr);
        return (addr & r.mask) == (r.base & r.mask);
    endfunction

endpackage

`default_nettype wire

// File: rtl/soc_router_err_slv.sv
// ============================================================================
// Module      : soc_router_err_slv
// Description : Decode-error slave behind the router's ERR port. Serves one
//               write burst and one read burst at a time. Writes: accept AW,
//               swallow W beats up to w_last, answer B with DECERR. Reads:
//               accept AR, return ar_len+1 zero beats with DECERR.
// Ports       : clk_i, rst_i (sync, active-high)
//               i_req  - AXI4 request from the router
//               o_resp - AXI4 response to the router
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module soc_router_err_slv
    import soc_router_pkg::*;
#(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  axi_req_t  i_req,
    output axi_resp_t o_resp
);

    localparam logic [DATA_WIDTH-1:0] c_ERR_DATA = '0;

    err_wr_state_e       r_wr_state;
    err_wr_state_e       w_wr_state_nxt;
    err_rd_state_e       r_rd_state;
    err_rd_state_e       w_rd_state_nxt;
    logic [ID_WIDTH-1:0] r_wr_id;
    logic [ID_WIDTH-1:0] r_rd_id;
    logic [7:0]          r_rd_len;
    logic [7:0]          r_rd_beat;
    logic                w_unused;

    // Payload fields that a decode-error slave has no use for.
    assign w_unused = ^{i_req.aw_addr, i_req.aw_len, i_req.aw_size, i_req.aw_burst,
                        i_req.w_data, i_req.w_strb, i_req.ar_addr, i_req.ar_size,
                        i_req.ar_burst};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_state <= WR_IDLE;
            r_rd_state <= RD_IDLE;
            r_wr_id    <= '0;
            r_rd_id    <= '0;
            r_rd_len   <= '0;
            r_rd_beat  <= '0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_rd_state <= w_rd_state_nxt;
            if (r_wr_state == WR_IDLE && i_req.aw_valid) begin
                r_wr_id <= i_req.aw_id;
            end
            if (r_rd_state == RD_IDLE && i_req.ar_valid) begin
                r_rd_id   <= i_req.ar_id;
                r_rd_len  <= i_req.ar_len;
                r_rd_beat <= '0;
            end else if (r_rd_state == RD_DATA && i_req.r_ready) begin
                r_rd_beat <= r_rd_beat + 8'd1;
            end
        end
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        unique case (r_wr_state)
            WR_IDLE: if (i_req.aw_valid)                  w_wr_state_nxt = WR_DATA;
            WR_DATA: if (i_req.w_valid && i_req.w_last)   w_wr_state_nxt = WR_RESP;
            WR_RESP: if (i_req.b_ready)                   w_wr_state_nxt = WR_IDLE;
            default:                                      w_wr_state_nxt = WR_IDLE;
        endcase

        w_rd_state_nxt = r_rd_state;
        unique case (r_rd_state)
            RD_IDLE: if (i_req.ar_valid) w_rd_state_nxt = RD_DATA;
            RD_DATA: if (i_req.r_ready && (r_rd_beat == r_rd_len)) w_rd_state_nxt = RD_IDLE;
            default: w_rd_state_nxt = RD_IDLE;
        endcase
    end

    // Outputs depend on registered state only, so no path exists from the
    // router's request back into its own ready/valid decisions.
    always_comb begin
        o_resp          = '0;
        o_resp.aw_ready = (r_wr_state == WR_IDLE);
        o_resp.w_ready  = (r_wr_state == WR_DATA);
        o_resp.b_valid  = (r_wr_state == WR_RESP);
        o_resp.b_id     = r_wr_id;
        o_resp.b_resp   = DECERR;
        o_resp.ar_ready = (r_rd_state == RD_IDLE);
        o_resp.r_valid  = (r_rd_state == RD_DATA);
        o_resp.r_id     = r_rd_id;
        o_resp.r_data   = c_ERR_DATA;
        o_resp.r_resp   = DECERR;
        o_resp.r_last   = (r_rd_state == RD_DATA) && (r_rd_beat == r_rd_len);
    end

endmodule

`default_nettype wire

// File: rtl/soc_addr_router.sv
// ============================================================================
// Module      : soc_addr_router
// Description : AXI4 1-to-N address router. AW and AR are decoded against a
//               rule table (lowest matching rule wins, no match -> internal
//               ERR port) and forwarded with zero latency. Each direction
//               locks onto one port while transactions are outstanding; W
//               follows AW order through a small port-index FIFO.
// Ports       : clk_i, rst_i (sync, active-high)
//               addr_map_i - NO_RULES x {port_idx, base, mask}
//               slv_req_i / slv_resp_o - upstream AXI4 bundle
//               mst_req_o / mst_resp_i - NO_MST_PORTS downstream bundles
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module soc_addr_router
    import soc_router_pkg::*;
#(
    parameter int unsigned NO_MST_PORTS = 9,
    parameter int unsigned NO_RULES     = 8,
    parameter int unsigned MAX_TRANS    = 2,
    parameter int unsigned ID_WIDTH     = 4,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  rule_t     addr_map_i [NO_RULES],
    input  axi_req_t  slv_req_i,
    output axi_resp_t slv_resp_o,
    output axi_req_t  mst_req_o  [NO_MST_PORTS],
    input  axi_resp_t mst_resp_i [NO_MST_PORTS]
);

    localparam int c_CNT_W  = $clog2(MAX_TRANS + 1);
    localparam int c_FIDX_W = (MAX_TRANS > 1) ? $clog2(MAX_TRANS) : 1;
    localparam logic [PORT_IDX_W-1:0] c_ERR_IDX = PORT_IDX_W'(NO_MST_PORTS);
    localparam logic [c_CNT_W-1:0]    c_CNT_MAX = c_CNT_W'(MAX_TRANS);
    localparam logic [c_CNT_W-1:0]    c_CNT_ONE = c_CNT_W'(1);

    // Index NO_MST_PORTS of these arrays is the internal ERR port.
    axi_req_t  w_req  [NO_MST_PORTS+1];
    axi_resp_t w_resp [NO_MST_PORTS+1];
    axi_resp_t w_err_resp;
    axi_resp_t w_slv_resp;

    logic [ADDR_WIDTH-1:0] w_aw_addr;
    logic [ADDR_WIDTH-1:0] w_ar_addr;
    logic [PORT_IDX_W-1:0] w_aw_dec;
    logic [PORT_IDX_W-1:0] w_ar_dec;
    logic                  w_aw_stall;
    logic                  w_ar_stall;

    logic [c_CNT_W-1:0]    r_aw_cnt;
    logic [c_CNT_W-1:0]    r_ar_cnt;
    logic [PORT_IDX_W-1:0] r_aw_port;
    logic [PORT_IDX_W-1:0] r_ar_port;

    logic [PORT_IDX_W-1:0] r_wfifo [MAX_TRANS];
    logic [c_CNT_W-1:0]    r_wf_cnt;
    logic [c_FIDX_W-1:0]   w_wf_widx;

    logic w_aw_hs, w_w_pop, w_b_hs, w_ar_hs, w_r_done;

    assign w_aw_addr = slv_req_i.aw_addr;
    assign w_ar_addr = slv_req_i.ar_addr;

    // Walk the rules from highest to lowest so the lowest match is left standing.
    always_comb begin
        w_aw_dec = c_ERR_IDX;
        w_ar_dec = c_ERR_IDX;
        for (int k = int'(NO_RULES) - 1; k >= 0; k--) begin
            if (rule_match(addr_map_i[k], w_aw_addr)) w_aw_dec = addr_map_i[k].port_idx;
            if (rule_match(addr_map_i[k], w_ar_addr)) w_ar_dec = addr_map_i[k].port_idx;
        end
    end

    // A direction may only switch ports once everything in flight has retired,
    // which keeps responses in order without per-ID tracking.
    assign w_aw_stall = (r_aw_cnt == c_CNT_MAX) ||
                        ((r_aw_cnt != '0) && (w_aw_dec != r_aw_port));
    assign w_ar_stall = (r_ar_cnt == c_CNT_MAX) ||
                        ((r_ar_cnt != '0) && (w_ar_dec != r_ar_port));

    always_comb begin
        for (int i = 0; i < int'(NO_MST_PORTS); i++) begin
            w_resp[i] = mst_resp_i[i];
        end
        w_resp[NO_MST_PORTS] = w_err_resp;
    end

    always_comb begin
        w_slv_resp = '0;
        for (int i = 0; i <= int'(NO_MST_PORTS); i++) begin
            w_req[i] = '0;
        end
        if (!rst_i) begin
            for (int i = 0; i <= int'(NO_MST_PORTS); i++) begin
                // Payload is broadcast; only the handshake signals are steered.
                w_req[i]          = slv_req_i;
                w_req[i].aw_valid = 1'b0;
                w_req[i].w_valid  = 1'b0;
                w_req[i].b_ready  = 1'b0;
                w_req[i].ar_valid = 1'b0;
                w_req[i].r_ready  = 1'b0;

                if (!w_aw_stall && (w_aw_dec == PORT_IDX_W'(i))) begin
                    w_req[i].aw_valid   = slv_req_i.aw_valid;
                    w_slv_resp.aw_ready = w_resp[i].aw_ready;
                end
                if ((r_wf_cnt != '0) && (r_wfifo[0] == PORT_IDX_W'(i))) begin
                    w_req[i].w_valid   = slv_req_i.w_valid;
                    w_slv_resp.w_ready = w_resp[i].w_ready;
                end
                if ((r_aw_cnt != '0) && (r_aw_port == PORT_IDX_W'(i))) begin
                    w_req[i].b_ready   = slv_req_i.b_ready;
                    w_slv_resp.b_valid = w_resp[i].b_valid;
                    w_slv_resp.b_id    = w_resp[i].b_id;
                    w_slv_resp.b_resp  = w_resp[i].b_resp;
                end
                if (!w_ar_stall && (w_ar_dec == PORT_IDX_W'(i))) begin
                    w_req[i].ar_valid   = slv_req_i.ar_valid;
                    w_slv_resp.ar_ready = w_resp[i].ar_ready;
                end
                if ((r_ar_cnt != '0) && (r_ar_port == PORT_IDX_W'(i))) begin
                    w_req[i].r_ready   = slv_req_i.r_ready;
                    w_slv_resp.r_valid = w_resp[i].r_valid;
                    w_slv_resp.r_id    = w_resp[i].r_id;
                    w_slv_resp.r_data  = w_resp[i].r_data;
                    w_slv_resp.r_resp  = w_resp[i].r_resp;
                    w_slv_resp.r_last  = w_resp[i].r_last;
                end
            end
        end
    end

    assign slv_resp_o = w_slv_resp;

    for (genvar g = 0; g < int'(NO_MST_PORTS); g++) begin : g_mst_out
        assign mst_req_o[g] = w_req[g];
    end

    assign w_aw_hs  = slv_req_i.aw_valid && w_slv_resp.aw_ready;
    assign w_w_pop  = slv_req_i.w_valid  && w_slv_resp.w_ready && slv_req_i.w_last;
    assign w_b_hs   = w_slv_resp.b_valid && slv_req_i.b_ready;
    assign w_ar_hs  = slv_req_i.ar_valid && w_slv_resp.ar_ready;
    assign w_r_done = w_slv_resp.r_valid && slv_req_i.r_ready && w_slv_resp.r_last;

    // With a simultaneous pop the queue shifts down, so the new entry lands one slot lower.
    assign w_wf_widx = c_FIDX_W'(w_w_pop ? (r_wf_cnt - c_CNT_ONE) : r_wf_cnt);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_aw_cnt  <= '0;
            r_ar_cnt  <= '0;
            r_aw_port <= '0;
            r_ar_port <= '0;
            r_wf_cnt  <= '0;
            for (int i = 0; i < int'(MAX_TRANS); i++) begin
                r_wfifo[i] <= '0;
            end
        end else begin
            if (w_aw_hs) r_aw_port <= w_aw_dec;
            if (w_ar_hs) r_ar_port <= w_ar_dec;

            if (w_aw_hs && !w_b_hs)      r_aw_cnt <= r_aw_cnt + c_CNT_ONE;
            else if (!w_aw_hs && w_b_hs) r_aw_cnt <= r_aw_cnt - c_CNT_ONE;

            if (w_ar_hs && !w_r_done)      r_ar_cnt <= r_ar_cnt + c_CNT_ONE;
            else if (!w_ar_hs && w_r_done) r_ar_cnt <= r_ar_cnt - c_CNT_ONE;

            if (w_w_pop) begin
                for (int i = 0; i < int'(MAX_TRANS) - 1; i++) begin
                    r_wfifo[i] <= r_wfifo[i+1];
                end
            end
            if (w_aw_hs) r_wfifo[w_wf_widx] <= w_aw_dec;

            if (w_aw_hs && !w_w_pop)      r_wf_cnt <= r_wf_cnt + c_CNT_ONE;
            else if (!w_aw_hs && w_w_pop) r_wf_cnt <= r_wf_cnt - c_CNT_ONE;
        end
    end

    soc_router_err_slv #(
        .ID_WIDTH   (ID_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_err_slv (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .i_req  (w_req[NO_MST_PORTS]),
        .o_resp (w_err_resp)
    );

endmodule

`default_nettype wire

// File: doc/soc_addr_router.md
SOC_ADDR_ROUTER -- requirements
Module: soc_addr_router

Interface
REQ-001 SHALL have parameter NO_MST_PORTS, default 9: number of downstream AXI4 master ports.
REQ-002 SHALL have parameter NO_RULES, default 8: number of address-map rules.
REQ-003 SHALL have parameter MAX_TRANS, default 2: maximum outstanding transactions per direction.
REQ-004 SHALL have parameters ID_WIDTH 4, ADDR_WIDTH 32 and DATA_WIDTH 32: AXI4 field widths.
REQ-005 SHALL have port clk_i, input, 1 bit: sole clock.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port addr_map_i, input, NO_RULES x rule_t: rules of {port_idx, base, mask}, static while traffic is in flight.
REQ-008 SHALL have port slv_req_i, input, axi_req_t: upstream AW/W/AR channels plus B/R ready.
REQ-009 SHALL have port slv_resp_o, output, axi_resp_t: upstream AW/W/AR ready plus B/R channels.
REQ-010 SHALL have port mst_req_o, output, NO_MST_PORTS x axi_req_t: downstream requests.
REQ-011 SHALL have port mst_resp_i, input, NO_MST_PORTS x axi_resp_t: downstream responses.

Function
REQ-012 SHALL decode each address as follows: rule k matches when (addr & mask) == (base & mask); the lowest matching k wins; no match selects the internal error port ERR = NO_MST_PORTS.
REQ-013 SHALL route the AW and AR paths independently, each with its own port register and its own outstanding counter (0..MAX_TRANS).
REQ-014 SHALL forward AW/AR combinationally: zero-cycle fall-through of valid, payload and ready to and from the selected port.
REQ-015 SHALL stall AW/AR (ready=0, downstream valid=0) while the counter equals MAX_TRANS.
REQ-016 SHALL also stall AW/AR while the counter is nonzero and the decoded port differs from the registered port, and SHALL release the stall in the cycle after the counter reaches 0.
REQ-017 SHALL increment the counter on an AW/AR handshake and decrement it on a B handshake or on an R handshake with r_last; a simultaneous increment and decrement SHALL leave the counter unchanged.
REQ-018 SHALL push the write port index into a MAX_TRANS-deep FIFO on each AW handshake and route W to the FIFO head; an empty FIFO SHALL hold w_ready at 0; a W handshake with w_last SHALL pop the FIFO.
REQ-019 SHALL take B and R only from the registered port, drive ready to that port only, and hold all other mst b_ready/r_ready at 0.
REQ-020 SHALL, as the ERR write responder, accept W beats with w_ready=1 until w_last, then present B with b_id=aw_id and b_resp=2'b11, holding B until b_ready.
REQ-021 SHALL, as the ERR read responder, return ar_len+1 beats of r_data=0, r_resp=2'b11, r_id=ar_id, asserting r_last on the final beat, with each beat held until r_ready.
REQ-022 SHALL handle ERR through the same counters and FIFO as a real port, and the responder SHALL serve one burst at a time per direction.

Reset
REQ-023 SHALL, while rst_i=1, clear all counters, registered ports, the W FIFO and the responder state.
REQ-024 SHALL, while rst_i=1, force every mst_req_o valid and ready to 0, and every slv_resp_o valid and ready to 0.
REQ-025 SHALL treat an assertion of rst_i mid-burst as an abort: all in-flight state is discarded and no response is owed after reset.

Structure
REQ-026 SHALL place rule_t, axi_req_t, axi_resp_t and the DECERR/OKAY constants in package soc_router_pkg.
REQ-027 SHALL implement the ERR responder as sub-module soc_router_err_slv.
REQ-028 SHALL implement the W FIFO inline as a counter-plus-array.

Verification
Default map for all scenarios: rule0 {1, 0x0000_0000, 0xF800_0000}; rule1 {3, 0x1FE4_0000, 0xFFFF_0000}; rule2 {5, 0x1FC0_0000, 0xFFF0_0000}.
REQ-029 SHALL be verified by this scenario: AR 0x0000_1000, len 3 -> mst1 ar_valid in the same cycle; 4 R beats pass through; AR counter returns to 0 after r_last.
REQ-030 SHALL be verified by this scenario: AW 0x1FE4_0010 then AW 0x0000_0000 while the first B is pending -> second AW stalls (ready=0) until mst3 B is handshaked, then goes to mst1.
REQ-031 SHALL be verified by this scenario: with MAX_TRANS=2, three back-to-back ARs to 0x1FC0_0000 -> third stalls until the first r_last.
REQ-032 SHALL be verified by this scenario: AW 0x3000_0000, id 5, len 1, two W beats -> no mst valid; B id=5, resp=2'b11; AR to the same address with len 2 -> 3 zero beats, resp 2'b11, r_last on beat 3.
REQ-033 SHALL be verified by this scenario: AW handshake followed by a 2-cycle W delay -> W routed to mst1; w_ready=0 before the AW is accepted.
REQ-034 SHALL be verified by this scenario: rst_i pulsed while a 4-beat ERR read is at beat 2 -> all valids 0 next cycle; counters 0; a fresh AR decodes correctly.
